attack_meter: RTL

- Multi-bar successor to the single moving timing bar in the fight box.
- Launches N_BARS staggered bars that sweep across the fight box. Each accepted UART key press freezes the front-most moving bar and scores it by its distance from the box centre.
- Accumulates damage, echoes accepted key bytes over the UART TX handshake, and signals completion to the battle controller.
- Sits between the UART RX/TX pair and the renderer; the renderer reads o_cx, o_cy, o_r, o_h and o_bar_state per bar.

---
 rtl/attack_meter_pkg.sv | 25 ++
 rtl/attack_meter_if.sv | 18 +
 rtl/attack_bar.sv | 84 ++++++++
 rtl/attack_meter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/attack_meter_pkg.sv
// Shared encodings and helpers for the multi-bar attack meter.
// Bar states, round FSM states, default key byte and the coordinate type.
package attack_meter_pkg;

  localparam int COORD_W = 16;
  typedef logic [COORD_W-1:0] coord_t;

  typedef logic [1:0] bar_state_t;
  localparam bar_state_t BAR_WAIT = 2'd0;
  localparam bar_state_t BAR_MOVE = 2'd1;
  localparam bar_state_t BAR_HIT  = 2'd2;
  localparam bar_state_t BAR_MISS = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] KEY_DEFAULT = 8'h20;

  // Compare first so the subtraction never wraps.
  function automatic coord_t abs_diff(input coord_t a, input coord_t b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/attack_meter_if.sv
// UART byte handshake between the RX/TX pair and the attack meter.
// The meter is the slave: it consumes RX bytes and produces TX echoes.
interface attack_meter_if;
  logic       i_rx_receive;
  logic [7:0] i_rx_data;
  logic       o_tx_transmit;
  logic [7:0] o_tx_data;

  modport master (
    output i_rx_receive, i_rx_data,
    input  o_tx_transmit, o_tx_data
  );

  modport slave (
    input  i_rx_receive, i_rx_data,
    output o_tx_transmit, o_tx_data
  );
endinterface

// File: rtl/attack_bar.sv
// One sweeping bar: position, direction and WAIT/MOVE/HIT/MISS state.
// A freeze wins over a step in the same cycle so the bar is scored where it stood.
module attack_bar
  import attack_meter_pkg::*;
#(
  parameter int FX       = 100,
  parameter int F_WIDTH  = 440,
  parameter int R        = 2,
  parameter int VELOCITY = 2,
  parameter int BOUNCE   = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       init_i,
  input  logic       launch_i,
  input  logic       step_i,
  input  logic       freeze_i,
  output coord_t     x_o,
  output bar_state_t state_o
);

  localparam coord_t X_MIN = coord_t'(FX + R);
  localparam coord_t X_MAX = coord_t'(FX + F_WIDTH - R);
  localparam logic [COORD_W:0] VEL = (COORD_W+1)'(VELOCITY);

  coord_t           x_q, x_d;
  bar_state_t       state_q, state_d;
  logic             dir_left_q, dir_left_d;
  logic [COORD_W:0] right_sum, left_lim;

  always_comb begin
    right_sum  = {1'b0, x_q} + VEL;
    left_lim   = {1'b0, X_MIN} + VEL;
    x_d        = x_q;
    state_d    = state_q;
    dir_left_d = dir_left_q;
    if (init_i) begin
      x_d        = X_MIN;
      state_d    = BAR_WAIT;
      dir_left_d = 1'b0;
    end else begin
      case (state_q)
        BAR_WAIT: if (launch_i) state_d = BAR_MOVE;
        BAR_MOVE: begin
          if (freeze_i) begin
            state_d = BAR_HIT;
          end else if (step_i) begin
            if (!dir_left_q) begin
              if (right_sum > {1'b0, X_MAX}) begin
                x_d = X_MAX;
                if (BOUNCE != 0) dir_left_d = 1'b1;
                else             state_d    = BAR_MISS;
              end else begin
                x_d = right_sum[COORD_W-1:0];
              end
            end else if ({1'b0, x_q} < left_lim) begin
              x_d     = X_MIN;
              state_d = BAR_MISS;
            end else begin
              x_d = x_q - VEL[COORD_W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q        <= X_MIN;
      state_q    <= BAR_WAIT;
      dir_left_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      state_q    <= state_d;
      dir_left_q <= dir_left_d;
    end
  end

  assign x_o     = x_q;
  assign state_o = state_q;

endmodule

// File: rtl/attack_meter.sv
// Multi-bar attack meter: launches staggered bars, scores key presses against
// the box centre, accumulates saturating damage and echoes accepted keys.
module attack_meter
  import attack_meter_pkg::*;
#(
  parameter int         N_BARS      = 3,
  parameter int         FX          = 100,
  parameter int         FY          = 230,
  parameter int         F_WIDTH     = 440,
  parameter int         F_HEIGHT    = 150,
  parameter int         R           = 2,
  parameter int         VELOCITY    = 2,
  parameter int         SPACING     = 40,
  parameter int         BOUNCE      = 0,
  parameter logic [7:0] KEY         = KEY_DEFAULT,
  parameter int         PERFECT_WIN = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ani_stb,
  input  logic                  i_animate,
  input  logic                  i_start,
  attack_meter_if.slave         uart,
  output logic [16*N_BARS-1:0]  o_cx,
  output logic [15:0]           o_cy,
  output logic [15:0]           o_r,
  output logic [15:0]           o_h,
  output logic [2*N_BARS-1:0]   o_bar_state,
  output logic [15:0]           o_damage,
  output logic [3:0]            o_hits,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam coord_t CENTRE = coord_t'(FX + F_WIDTH / 2);
  localparam coord_t HALF   = coord_t'(F_WIDTH / 2);
  localparam coord_t PWIN   = coord_t'(PERFECT_WIN);

  logic [1:0]  fsm_q;
  logic [15:0] cnt_q;
  logic [15:0] damage_q, damage_d;
  logic [3:0]  hits_q;
  logic        tx_q;
  logic [7:0]  tx_data_q;

  logic run, stb, press, init, press_hit;
  coord_t      bar_x  [N_BARS];
  bar_state_t  bar_st [N_BARS];
  logic [N_BARS-1:0] sel;
  logic        tgt_found, all_resolved;
  coord_t      tgt_x, err, base;
  logic [16:0] pts;
  logic [17:0] sum;

  assign run       = (fsm_q == ST_RUN);
  assign stb       = run & i_ani_stb & i_animate;
  assign press     = run & uart.i_rx_receive & (uart.i_rx_data == KEY);
  assign init      = i_start & ~run;
  assign press_hit = press & tgt_found;

  // Front-most bar is the lowest index still moving; HIT and MISS both set bit 1.
  always_comb begin
    sel          = '0;
    tgt_found    = 1'b0;
    tgt_x        = bar_x[0];
    all_resolved = 1'b1;
    for (int k = 0; k < N_BARS; k++) begin
      if (!tgt_found && bar_st[k] == BAR_MOVE) begin
        tgt_found = 1'b1;
        sel[k]    = 1'b1;
        tgt_x     = bar_x[k];
      end
      all_resolved = all_resolved & bar_st[k][1];
    end
  end

  always_comb begin
    err      = abs_diff(tgt_x, CENTRE);
    base     = (err > HALF) ? '0 : (HALF - err);
    pts      = (err <= PWIN) ? {base, 1'b0} : {1'b0, base};
    sum      = {2'b00, damage_q} + {1'b0, pts};
    damage_d = (sum[17:16] != 2'b00) ? 16'hFFFF : sum[15:0];
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_BARS; gi++) begin : g_bar
      attack_bar #(
        .FX(FX), .F_WIDTH(F_WIDTH), .R(R), .VELOCITY(VELOCITY), .BOUNCE(BOUNCE)
      ) u_bar (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .init_i   (init),
        .launch_i (stb && (cnt_q == 16'(gi * SPACING))),
        .step_i   (stb),
        .freeze_i (press && sel[gi]),
        .x_o      (bar_x[gi]),
        .state_o  (bar_st[gi])
      );
      assign o_cx[16*gi +: 16]       = bar_x[gi];
      assign o_bar_state[2*gi +: 2]  = bar_st[gi];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fsm_q     <= ST_IDLE;
      cnt_q     <= '0;
      damage_q  <= '0;
      hits_q    <= '0;
      tx_q      <= 1'b0;
      tx_data_q <= '0;
    end else begin
      tx_q <= 1'b0;
      if (init) begin
        fsm_q    <= ST_RUN;
        cnt_q    <= '0;
        damage_q <= '0;
        hits_q   <= '0;
      end else if (run) begin
        if (all_resolved) fsm_q <= ST_DONE;
        if (stb && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        if (press_hit) begin
          damage_q  <= damage_d;
          hits_q    <= hits_q + 4'd1;
          tx_q      <= 1'b1;
          tx_data_q <= KEY;
        end
      end
    end
  end

  assign o_cy               = 16'(FY);
  assign o_r                = 16'(R);
  assign o_h                = 16'(F_HEIGHT);
  assign o_damage           = damage_q;
  assign o_hits             = hits_q;
  assign o_busy             = run;
  assign o_done             = (fsm_q == ST_DONE);
  assign uart.o_tx_transmit = tx_q;
  assign uart.o_tx_data     = tx_data_q;

endmodule
